winograd_kernel_scheduler: RTL and testbench
============================================

Name: winograd_kernel_scheduler

Overview:
Sequences the 3x3->6x6 Winograd kernel transform unit over a batch of kernels.
- Per kernel: fetches 9 taps from kernel memory and assembles the 3x3 tile, pulses the transform start, waits for transform done.
- Then streams the 36 transformed coefficients into the U buffer with backpressure.
- Sits between the kernel SRAM, the kernel transform unit and the U buffer consumed by the element-wise multiply stage.

Parameters:
NUM_KERNELS, 4, maximum kernels per job.
ADDR_W, 8, address width of kernel memory and U buffer. Requires NUM_KERNELS*36 <= 2**ADDR_W.
DATA_W, 16, element width.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  job request; sampled in IDLE only
kernel_count  in  $clog2(NUM_KERNELS+1)  kernels in job; sampled with start
busy  out  1  high from the cycle after accepted start until the done pulse, inclusive
done  out  1  one-cycle job-complete pulse
kmem_rd_en  out  1  kernel memory read strobe
kmem_rd_addr  out  ADDR_W  read address
kmem_rd_data  in  DATA_W  read data, valid exactly 1 cycle after rd_en
ktu_start  out  1  one-cycle transform start
ktu_kernel  out  DATA_W x[0:2][0:2]  assembled 3x3 kernel to transform
ktu_done  in  1  transform complete pulse
ktu_kernel_out  in  DATA_W x[0:5][0:5]  transformed 6x6 kernel
u_wr_en  out  1  U buffer write valid
u_wr_addr  out  ADDR_W  U buffer address
u_wr_data  out  DATA_W  U buffer data
u_wr_ready  in  1  U buffer accept

Behaviour:
- Reset: state IDLE; k=0; all outputs 0, including ktu_kernel.
- Reset asserted mid-job aborts immediately; no done pulse.
- States: IDLE -> FETCH -> LAUNCH -> WAIT -> WRITE -> (FETCH | FIN) -> IDLE.
- IDLE:
  - start=1: latch count = min(kernel_count, NUM_KERNELS), k=0.
  - count=0: go to FIN, giving done one cycle later with no memory traffic.
  - otherwise go to FETCH.
- FETCH:
  - Issue 9 consecutive reads, one per cycle, at addr = k*9+i, i=0..8.
  - Data returned for index i goes to ktu_kernel[i/3][i%3] (row-major).
  - After the 9th datum is captured (10 cycles in FETCH), go to LAUNCH.
- LAUNCH: ktu_start=1 for exactly one cycle, then WAIT. ktu_kernel holds stable from LAUNCH until the next FETCH.
- WAIT:
  - Stay until ktu_done=1, then WRITE.
  - ktu_done outside WAIT is ignored.
  - No timeout.
- WRITE:
  - 36 writes, j=0..35, r=j/6, c=j%6.
  - u_wr_addr = k*36+j, u_wr_data = ktu_kernel_out[r][c].
  - u_wr_en held high with addr/data stable until u_wr_ready=1. The handshake (en&ready) advances j.
  - After handshake j=35: if k+1 < count then k++ and FETCH, else FIN.
- FIN: done=1 for one cycle, busy=1 in that cycle, then IDLE.
- start while not in IDLE is ignored; kernel_count changes mid-job are ignored.
- The transformed output is relied on to be stable; ktu_start is never pulsed again before WRITE finishes.
- No-stall, 4-cycle transform, count=1: done asserted 52 cycles after the accepted start (10 FETCH + 1 LAUNCH + 4 WAIT + 36 WRITE + 1 FIN).
- Addresses are unsigned, no wrap checking beyond the parameter constraint.

Optional Feature:
- WKS_PREFETCH_EN defined:
  - During WRITE of kernel k (k+1<count), the 9 reads of kernel k+1 are issued into a shadow 3x3 register.
  - On leaving WRITE, the shadow copies into ktu_kernel and the FSM goes directly to LAUNCH, skipping FETCH.
  - Per-kernel steady-state cost drops by 10 cycles.
  - Reads may still be in flight when WRITE ends (under backpressure): the FSM waits in FETCH until all 9 are captured.
- Undefined: strictly serial behaviour as above; no shadow register.

Decomposition:
- Package winograd_pkg:
  - DATA_W default, KERNEL_TAPS=9, U_TAPS=36.
  - Typedef for state enum wks_state_t {IDLE, FETCH, LAUNCH, WAIT, WRITE, FIN}.
  - Typedefs kernel3_t and kernel6_t for the 3x3/6x6 arrays.
- No sub-module is natural: a single FSM with tap, write and kernel counters.

Test Plan:
- count=1, mem[0..8]=1..9, 4-cycle KTU model, ready=1 -> 9 reads at addr 0..8; ktu_kernel={1,2,3;4,5,6;7,8,9}; single ktu_start; 36 writes at addr 0..35 matching the model; done 52 cycles after start.
- count=3, ready=1 -> reads at 0..26, writes at 0..107, three ktu_start pulses, one done, busy continuous.
- count=1, u_wr_ready toggling 1/0 each cycle plus 5-cycle stall at j=17 -> addr/data stable while stalled, exactly 36 handshakes, no duplicates.
- count=0 -> done one cycle after start, no kmem_rd_en/ktu_start/u_wr_en activity; count=7 with NUM_KERNELS=4 -> exactly 4 kernels processed.
- rst_n low during WRITE j=20 -> all outputs 0 same cycle, no done; a subsequent start with count=1 completes normally.
- WKS_PREFETCH_EN, count=2 -> kernel 1 reads (addr 9..17) overlap kernel 0 writes; done 10 cycles earlier than without the macro.

Source files
------------

// File: rtl/winograd_pkg.sv
// Shared types, sizes and index helpers for the Winograd kernel-transform scheduler.
package winograd_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int KERNEL_TAPS = 9;
    localparam int U_TAPS      = 36;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LAUNCH = 3'd2,
        WAIT   = 3'd3,
        WRITE  = 3'd4,
        FIN    = 3'd5
    } wks_state_t;

    typedef logic [DATA_W_DEF-1:0] kernel3_t [0:2][0:2];
    typedef logic [DATA_W_DEF-1:0] kernel6_t [0:5][0:5];

    // Row-major position of a tap / coefficient index inside its tile.
    function automatic logic [1:0] tap_row(input logic [3:0] i);
        return 2'(i / 4'd3);
    endfunction

    function automatic logic [1:0] tap_col(input logic [3:0] i);
        return 2'(i % 4'd3);
    endfunction

    function automatic logic [2:0] u_row(input logic [5:0] j);
        return 3'(j / 6'd6);
    endfunction

    function automatic logic [2:0] u_col(input logic [5:0] j);
        return 3'(j % 6'd6);
    endfunction

endpackage

// File: rtl/winograd_kernel_scheduler.sv
// Sequences kernel fetch -> 3x3->6x6 transform -> U-buffer write for a batch of kernels.
// Latency: 52 cycles from accepted start to done for one kernel with a 4-cycle transform and no stalls.
// Backpressure: u_wr_en holds addr/data until u_wr_ready; WKS_PREFETCH_EN overlaps the next fetch with writes.
module winograd_kernel_scheduler
    import winograd_pkg::*;
#(
    parameter int NUM_KERNELS = 4,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = DATA_W_DEF
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic [$clog2(NUM_KERNELS+1)-1:0]   kernel_count,
    output logic                               busy,
    output logic                               done,
    output logic                               kmem_rd_en,
    output logic [ADDR_W-1:0]                  kmem_rd_addr,
    input  logic [DATA_W-1:0]                  kmem_rd_data,
    output logic                               ktu_start,
    output logic [DATA_W-1:0]                  ktu_kernel [0:2][0:2],
    input  logic                               ktu_done,
    input  logic [DATA_W-1:0]                  ktu_kernel_out [0:5][0:5],
    output logic                               u_wr_en,
    output logic [ADDR_W-1:0]                  u_wr_addr,
    output logic [DATA_W-1:0]                  u_wr_data,
    input  logic                               u_wr_ready
);

    localparam int CW = $clog2(NUM_KERNELS + 1);

    wks_state_t        state_q;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     k_q;
    logic [CW-1:0]     count_clamped;
    logic [3:0]        tap_q;
    logic [5:0]        j_q;
    logic              rd_vld_q;
    logic [3:0]        rd_idx_q;
    logic              more_kernels;
    logic              wr_hs;
    logic [ADDR_W-1:0] k_base9;
    logic [ADDR_W-1:0] k_base36;
    logic [ADDR_W-1:0] rd_base;

    assign count_clamped = (kernel_count > CW'(NUM_KERNELS)) ? CW'(NUM_KERNELS) : kernel_count;
    assign more_kernels  = (k_q + CW'(1)) < cnt_q;
    assign wr_hs         = u_wr_en & u_wr_ready;
    assign k_base9       = ADDR_W'(k_q) * ADDR_W'(KERNEL_TAPS);
    assign k_base36      = ADDR_W'(k_q) * ADDR_W'(U_TAPS);

`ifdef WKS_PREFETCH_EN
    logic [DATA_W-1:0] shadow_q [0:2][0:2];
    logic              rd_shadow_q;
    logic              pf_full_q;
    logic              pf_wait_q;
    logic              pf_rd;

    // Reads for kernel k+1 run during WRITE and, if they spill over, in FETCH with pf_wait_q set.
    assign pf_rd      = (tap_q < 4'd9) &&
                        ((state_q == WRITE && more_kernels) || (state_q == FETCH && pf_wait_q));
    assign kmem_rd_en = (tap_q < 4'd9) &&
                        (state_q == FETCH || (state_q == WRITE && more_kernels));
    assign rd_base    = (state_q == WRITE) ? k_base9 + ADDR_W'(KERNEL_TAPS) : k_base9;
`else
    assign kmem_rd_en = (state_q == FETCH) && (tap_q < 4'd9);
    assign rd_base    = k_base9;
`endif

    assign kmem_rd_addr = kmem_rd_en ? rd_base + ADDR_W'(tap_q) : '0;
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == FIN);
    assign ktu_start    = (state_q == LAUNCH);
    assign u_wr_en      = (state_q == WRITE);
    assign u_wr_addr    = u_wr_en ? k_base36 + ADDR_W'(j_q) : '0;
    assign u_wr_data    = u_wr_en ? ktu_kernel_out[u_row(j_q)][u_col(j_q)] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            k_q      <= '0;
            tap_q    <= '0;
            j_q      <= '0;
            rd_vld_q <= 1'b0;
            rd_idx_q <= '0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    ktu_kernel[r][c] <= '0;
`ifdef WKS_PREFETCH_EN
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    shadow_q[r][c] <= '0;
            rd_shadow_q <= 1'b0;
            pf_full_q   <= 1'b0;
            pf_wait_q   <= 1'b0;
`endif
        end else begin
            rd_vld_q <= kmem_rd_en;
            rd_idx_q <= tap_q;
            if (kmem_rd_en)
                tap_q <= tap_q + 4'd1;

`ifdef WKS_PREFETCH_EN
            rd_shadow_q <= pf_rd;
            if (rd_vld_q && rd_shadow_q) begin
                shadow_q[tap_row(rd_idx_q)][tap_col(rd_idx_q)] <= kmem_rd_data;
                if (rd_idx_q == 4'd8)
                    pf_full_q <= 1'b1;
            end else if (rd_vld_q) begin
                ktu_kernel[tap_row(rd_idx_q)][tap_col(rd_idx_q)] <= kmem_rd_data;
            end
`else
            if (rd_vld_q)
                ktu_kernel[tap_row(rd_idx_q)][tap_col(rd_idx_q)] <= kmem_rd_data;
`endif

            case (state_q)
                IDLE: begin
`ifdef WKS_PREFETCH_EN
                    pf_wait_q <= 1'b0;
`endif
                    if (start) begin
                        cnt_q   <= count_clamped;
                        k_q     <= '0;
                        tap_q   <= '0;
                        state_q <= (count_clamped == '0) ? FIN : FETCH;
                    end
                end
                FETCH: begin
`ifdef WKS_PREFETCH_EN
                    if (pf_wait_q) begin
                        if (pf_full_q) begin
                            ktu_kernel <= shadow_q;
                            pf_wait_q  <= 1'b0;
                            state_q    <= LAUNCH;
                        end
                    end else
`endif
                    if (rd_vld_q && rd_idx_q == 4'd8)
                        state_q <= LAUNCH;
                end
                LAUNCH: state_q <= WAIT;
                WAIT: begin
                    if (ktu_done) begin
                        j_q     <= '0;
                        tap_q   <= '0;
                        state_q <= WRITE;
`ifdef WKS_PREFETCH_EN
                        pf_full_q <= 1'b0;
`endif
                    end
                end
                WRITE: begin
                    if (wr_hs) begin
                        j_q <= j_q + 6'd1;
                        if (j_q == 6'(U_TAPS - 1)) begin
                            j_q <= '0;
                            if (more_kernels) begin
                                k_q <= k_q + CW'(1);
`ifdef WKS_PREFETCH_EN
                                if (pf_full_q) begin
                                    ktu_kernel <= shadow_q;
                                    state_q    <= LAUNCH;
                                end else begin
                                    pf_wait_q <= 1'b1;
                                    state_q   <= FETCH;
                                end
`else
                                tap_q   <= '0;
                                state_q <= FETCH;
`endif
                            end else begin
                                state_q <= FIN;
                            end
                        end
                    end
                end
                FIN:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_winograd_kernel_scheduler.sv
// Directed bench for winograd_kernel_scheduler with kernel-memory, transform-unit and U-buffer models.
module tb_winograd_kernel_scheduler;
    import winograd_pkg::*;

    localparam int NK = 4;
    localparam int AW = 8;
    localparam int DW = 16;
`ifdef WKS_PREFETCH_EN
    localparam int EXP_LAT2 = 93;
    localparam int EXP_OVL  = 9;
`else
    localparam int EXP_LAT2 = 103;
    localparam int EXP_OVL  = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    kernel_count = '0;
    logic          busy, done;
    logic          kmem_rd_en;
    logic [AW-1:0] kmem_rd_addr;
    logic [DW-1:0] kmem_rd_data = '0;
    logic          ktu_start;
    kernel3_t      ktu_kernel;
    logic          ktu_done = 1'b0;
    kernel6_t      ktu_out;
    logic          u_wr_en;
    logic [AW-1:0] u_wr_addr;
    logic [DW-1:0] u_wr_data;
    logic          u_wr_ready = 1'b1;

    winograd_kernel_scheduler #(.NUM_KERNELS(NK), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .kernel_count(kernel_count),
        .busy(busy), .done(done),
        .kmem_rd_en(kmem_rd_en), .kmem_rd_addr(kmem_rd_addr), .kmem_rd_data(kmem_rd_data),
        .ktu_start(ktu_start), .ktu_kernel(ktu_kernel), .ktu_done(ktu_done),
        .ktu_kernel_out(ktu_out),
        .u_wr_en(u_wr_en), .u_wr_addr(u_wr_addr), .u_wr_data(u_wr_data), .u_wr_ready(u_wr_ready)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Kernel memory: mem[a] = a+1, read data one cycle after the strobe.
    logic [DW-1:0] mem [0:255];
    always @(posedge clk) if (kmem_rd_en) kmem_rd_data <= mem[kmem_rd_addr];

    // Transform model: done 4 cycles after start; out[r][c] = in[r%3][c%3] + 16r + c.
    int ktu_cnt = 0;
    always @(posedge clk) begin
        ktu_done <= 1'b0;
        if (ktu_start) begin
            ktu_cnt <= 3;
            for (int r = 0; r < 6; r++)
                for (int c = 0; c < 6; c++)
                    ktu_out[r][c] <= ktu_kernel[r % 3][c % 3] + 16'(r * 16 + c);
        end else if (ktu_cnt != 0) begin
            ktu_cnt <= ktu_cnt - 1;
            if (ktu_cnt == 1) ktu_done <= 1'b1;
        end
    end

    int       rd_addrs[$];
    int       wr_addrs[$];
    int       wr_datas[$];
    int       n_start, n_done, busy_gaps, rd_in_wr, stall_cycles, stab_err;
    logic     stalled_prev;
    logic [AW-1:0] prev_a;
    logic [DW-1:0] prev_d;
    kernel3_t snap;

    always @(negedge clk) begin
        if (kmem_rd_en) begin
            rd_addrs.push_back(int'(kmem_rd_addr));
            if (u_wr_en) rd_in_wr++;
        end
        if (u_wr_en && u_wr_ready) begin
            wr_addrs.push_back(int'(u_wr_addr));
            wr_datas.push_back(int'(u_wr_data));
        end
        if (u_wr_en) begin
            if (stalled_prev && (u_wr_addr !== prev_a || u_wr_data !== prev_d)) stab_err++;
            if (!u_wr_ready) stall_cycles++;
            stalled_prev = !u_wr_ready;
            prev_a = u_wr_addr;
            prev_d = u_wr_data;
        end else begin
            stalled_prev = 1'b0;
        end
        if (ktu_start) begin
            if (n_start == 0) snap = ktu_kernel;
            n_start++;
        end
        if (done) n_done++;
    end

    // U-buffer ready: always 1, or toggling with a 5-cycle hold-off when j=17 is presented.
    int   rdy_mode = 0;
    int   stall_left = 0;
    logic tog = 1'b1;
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0) begin
            u_wr_ready = 1'b1;
        end else if (wr_addrs.size() == 17 && stall_left > 0) begin
            u_wr_ready = 1'b0;
            stall_left--;
        end else begin
            u_wr_ready = tog;
            tog = !tog;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_u(input int i);
        int k, j, r, c;
        k = i / 36; j = i % 36; r = j / 6; c = j % 6;
        return k * 9 + (r % 3) * 3 + (c % 3) + 1 + r * 16 + c;
    endfunction

    task automatic do_job(input int kc, input int abort_at, output int lat);
        @(negedge clk); #1;
        rd_addrs.delete(); wr_addrs.delete(); wr_datas.delete();
        n_start = 0; n_done = 0; busy_gaps = 0; rd_in_wr = 0;
        stall_cycles = 0; stab_err = 0; stalled_prev = 1'b0;
        kernel_count = 3'(kc);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 2000; c++) begin
            @(negedge clk); #1;
            if (!busy) busy_gaps++;
            if ((abort_at >= 0 && wr_addrs.size() == abort_at) || done) begin
                lat = c;
                break;
            end
        end
        chk("job_finished_in_budget", int'(lat > 0), 1);
    endtask

    task automatic check_logs(input string tag, input int keff);
        int bad;
        bad = 0;
        chk({tag, "_rd_count"}, rd_addrs.size(), 9 * keff);
        foreach (rd_addrs[i]) if (rd_addrs[i] != i) bad++;
        chk({tag, "_rd_addr_bad"}, bad, 0);
        chk({tag, "_wr_count"}, wr_addrs.size(), 36 * keff);
        bad = 0;
        foreach (wr_addrs[i]) if (wr_addrs[i] != i) bad++;
        chk({tag, "_wr_addr_bad"}, bad, 0);
        bad = 0;
        foreach (wr_datas[i]) if (wr_datas[i] != exp_u(i)) bad++;
        chk({tag, "_wr_data_bad"}, bad, 0);
        chk({tag, "_ktu_starts"}, n_start, keff);
    endtask

    initial begin
        int lat;
        for (int a = 0; a < 256; a++) mem[a] = 16'(a + 1);

        // Reset state
        #2;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rd_en", int'(kmem_rd_en), 0);
        chk("rst_ktu_start", int'(ktu_start), 0);
        chk("rst_wr_en", int'(u_wr_en), 0);
        chk("rst_wr_addr", int'(u_wr_addr), 0);
        for (int i = 0; i < 9; i++)
            chk($sformatf("rst_ktu_kernel_%0d", i), int'(ktu_kernel[i / 3][i % 3]), 0);
        @(negedge clk); #1;
        rst_n = 1'b1;

        // Single kernel, no stalls
        do_job(1, -1, lat);
        chk("k1_done_latency", lat, 52);
        chk("k1_busy_gaps", busy_gaps, 0);
        check_logs("k1", 1);
        for (int i = 0; i < 9; i++)
            chk($sformatf("k1_ktu_kernel_%0d", i), int'(snap[i / 3][i % 3]), i + 1);
        @(negedge clk); #1;
        chk("k1_busy_after_done", int'(busy), 0);
        chk("k1_done_one_cycle", n_done, 1);

        // Three kernels back to back
        do_job(3, -1, lat);
        chk("k3_done_latency", lat, 154);
        chk("k3_busy_gaps", busy_gaps, 0);
        check_logs("k3", 3);
        @(negedge clk); #1;
        chk("k3_done_count", n_done, 1);

        // Toggling ready plus 5-cycle stall at j=17
        rdy_mode = 1; stall_left = 5; tog = 1'b1;
        do_job(1, -1, lat);
        rdy_mode = 0;
        check_logs("bp", 1);
        chk("bp_stable_while_stalled", stab_err, 0);
        chk("bp_stall_seen", int'(stall_cycles >= 5), 1);

        // Empty job and clamped over-count
        do_job(0, -1, lat);
        chk("k0_done_latency", lat, 1);
        check_logs("k0", 0);
        do_job(7, -1, lat);
        check_logs("k7_clamped", 4);

        // Reset mid-WRITE at j=20, then a normal job
        do_job(1, 20, lat);
        chk("abort_wr_en_before", int'(u_wr_en), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_wr_en", int'(u_wr_en), 0);
        chk("abort_wr_addr", int'(u_wr_addr), 0);
        chk("abort_wr_data", int'(u_wr_data), 0);
        chk("abort_rd_en", int'(kmem_rd_en), 0);
        chk("abort_ktu_kernel_22", int'(ktu_kernel[2][2]), 0);
        repeat (3) @(negedge clk);
        #1;
        chk("abort_no_done", n_done, 0);
        rst_n = 1'b1;
        do_job(1, -1, lat);
        chk("post_abort_latency", lat, 52);
        check_logs("post_abort", 1);

        // Two kernels: prefetch overlap and latency depend on the build
        do_job(2, -1, lat);
        chk("k2_done_latency", lat, EXP_LAT2);
        chk("k2_reads_during_write", rd_in_wr, EXP_OVL);
        check_logs("k2", 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
